// File: rtl/canyon_input_ctrl.sv
// Canyon Bomber input front-end: PS/2 key decode, joystick merge and a one-button
// credit sequencer (coin pulse, gap, start pulse). All outputs registered, active-low.
module canyon_input_ctrl #(
  parameter int COIN_CYC  = 240000,
  parameter int GAP_CYC   = 120000,
  parameter int START_CYC = 240000,
  parameter int CNT_W     = 20
) (
  input  logic        clk_sys,
  input  logic        Reset_I,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic        Coin1_O,
  output logic        Coin2_O,
  output logic        Start1_O,
  output logic        Start2_O,
  output logic        Fire1_O,
  output logic        Fire2_O,
  output logic        seq_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_START
  } state_t;

  localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);

  logic r_primed;
  logic r_toggle;
  logic r_k_fire1, r_k_fire2, r_k_play1, r_k_play2;
  logic r_k_start1, r_k_start2, r_k_coin1, r_k_coin2;
  logic r_p1_q, r_p2_q;
  logic r_player;
  logic [CNT_W-1:0] r_cnt;
  state_t r_state;

  logic w_event;
  logic w_p1, w_p2, w_p1_edge, w_p2_edge;
  logic w_seq_coin, w_seq_start;
  logic w_player_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  state_t w_state_nxt;
  logic w_unused_js;

  assign w_unused_js = &{1'b0, joystick_0[15:6], joystick_0[3:0],
                         joystick_1[15:6], joystick_1[3:0]};

  // Decode is held off for one cycle after reset so a stale toggle never looks like an event.
  assign w_event = r_primed & (ps2_key[10] ^ r_toggle);

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      r_primed <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      r_toggle <= ps2_key[10];
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      r_k_fire1  <= 1'b0;
      r_k_fire2  <= 1'b0;
      r_k_play1  <= 1'b0;
      r_k_play2  <= 1'b0;
      r_k_start1 <= 1'b0;
      r_k_start2 <= 1'b0;
      r_k_coin1  <= 1'b0;
      r_k_coin2  <= 1'b0;
    end else if (w_event) begin
      case (ps2_key[8:0])
        9'h029, 9'h014: r_k_fire1  <= ps2_key[9];
        9'h01C:         r_k_fire2  <= ps2_key[9];
        9'h005:         r_k_play1  <= ps2_key[9];
        9'h006:         r_k_play2  <= ps2_key[9];
        9'h016:         r_k_start1 <= ps2_key[9];
        9'h01E:         r_k_start2 <= ps2_key[9];
        9'h02E:         r_k_coin1  <= ps2_key[9];
        9'h036:         r_k_coin2  <= ps2_key[9];
        default:        ;
      endcase
    end
  end

  assign w_p1      = r_k_play1 | joystick_0[5];
  assign w_p2      = r_k_play2 | joystick_1[5];
  assign w_p1_edge = w_p1 & ~r_p1_q;
  assign w_p2_edge = w_p2 & ~r_p2_q;

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      r_p1_q <= 1'b0;
      r_p2_q <= 1'b0;
    end else begin
      r_p1_q <= w_p1;
      r_p2_q <= w_p2;
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_player <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_player <= w_player_nxt;
    end
  end

  // r_player: 0 = player 1, 1 = player 2. Play edges outside IDLE are dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_player_nxt = r_player;
    w_seq_coin   = 1'b0;
    w_seq_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_p1_edge || w_p2_edge) begin
          w_player_nxt = ~w_p1_edge;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_COIN;
        end
      end
      S_COIN: begin
        w_seq_coin = 1'b1;
        if (r_cnt == COIN_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_START;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_START: begin
        w_seq_start = 1'b1;
        if (r_cnt == START_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      Coin1_O  <= 1'b1;
      Coin2_O  <= 1'b1;
      Start1_O <= 1'b1;
      Start2_O <= 1'b1;
      Fire1_O  <= 1'b1;
      Fire2_O  <= 1'b1;
      seq_busy <= 1'b0;
    end else begin
      Coin1_O  <= ~(w_seq_coin | r_k_coin1);
      Coin2_O  <= ~(w_seq_coin | r_k_coin2);
      Start1_O <= ~((w_seq_start & ~r_player) | r_k_start1);
      Start2_O <= ~((w_seq_start & r_player) | r_k_start2);
      Fire1_O  <= ~(r_k_fire1 | joystick_0[4]);
      Fire2_O  <= ~(r_k_fire2 | joystick_1[4]);
      seq_busy <= (r_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_canyon_input_ctrl.sv
// Scoreboard bench for canyon_input_ctrl with short sequencer timings.
module tb_canyon_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        Reset_I;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic Coin1_O, Coin2_O, Start1_O, Start2_O, Fire1_O, Fire2_O, seq_busy;

  canyon_input_ctrl #(
    .COIN_CYC (4),
    .GAP_CYC  (2),
    .START_CYC(3),
    .CNT_W    (20)
  ) dut (
    .clk_sys   (clk_sys),
    .Reset_I   (Reset_I),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .Coin1_O   (Coin1_O),
    .Coin2_O   (Coin2_O),
    .Start1_O  (Start1_O),
    .Start2_O  (Start2_O),
    .Fire1_O   (Fire1_O),
    .Fire2_O   (Fire2_O),
    .seq_busy  (seq_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Vector order: {busy, Fire2, Fire1, Start2, Start1, Coin2, Coin1}
  logic [6:0] w_obs;
  assign w_obs = {seq_busy, Fire2_O, Fire1_O, Start2_O, Start1_O, Coin2_O, Coin1_O};

  localparam logic [6:0] V_IDLE   = 7'b0111111;
  localparam logic [6:0] V_FIRE1  = 7'b0101111;
  localparam logic [6:0] V_FIRE2  = 7'b0011111;
  localparam logic [6:0] V_COIN   = 7'b1111100;
  localparam logic [6:0] V_GAP    = 7'b1111111;
  localparam logic [6:0] V_START1 = 7'b1111011;
  localparam logic [6:0] V_START2 = 7'b1110111;
  localparam logic [6:0] V_KC1    = 7'b0111110;
  localparam logic [6:0] V_KC1_SC = 7'b1111100;
  localparam logic [6:0] V_KC1_GP = 7'b1111110;
  localparam logic [6:0] V_KC1_ST = 7'b1111010;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic tog      = 1'b0;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (busy,F2,F1,S2,S1,C2,C1)", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_n(input int n, input string tag, input logic [6:0] exp);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{tag, exp});
      tick();
      e = sb.pop_front();
      check(e.tag, w_obs, e.exp);
    end
  endtask

  task automatic check_now(input string tag, input logic [6:0] exp);
    exp_t e;
    sb.push_back('{tag, exp});
    e = sb.pop_front();
    check(e.tag, w_obs, e.exp);
  endtask

  task automatic ps2(input logic pressed, input logic [8:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_I    = 1'b0;
    ps2_key    = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    #12;
    check_now("reset_state", V_IDLE);
    @(posedge clk_sys);
    #1 Reset_I = 1'b1;
    expect_n(2, "idle_after_reset", V_IDLE);

    // Space press/release: two-cycle latency
    ps2(1'b1, 9'h029);
    expect_n(1, "space_lat1", V_IDLE);
    expect_n(3, "space_held", V_FIRE1);
    // Ctrl shares fire1: the last event wins
    ps2(1'b1, 9'h014);
    expect_n(2, "ctrl_press", V_FIRE1);
    ps2(1'b0, 9'h014);
    expect_n(1, "ctrl_rel_lat", V_FIRE1);
    expect_n(2, "ctrl_rel_wins", V_IDLE);
    ps2(1'b0, 9'h029);
    expect_n(2, "space_rel", V_IDLE);

    ps2(1'b1, 9'h01C);
    expect_n(1, "fire2_lat", V_IDLE);
    expect_n(1, "fire2_key", V_FIRE2);
    ps2(1'b0, 9'h01C);
    expect_n(1, "fire2_rel_lat", V_FIRE2);
    expect_n(1, "fire2_rel", V_IDLE);
    joystick_1[4] = 1'b1;
    expect_n(1, "fire2_joy", V_FIRE2);
    joystick_1[4] = 1'b0;
    expect_n(1, "fire2_joy_rel", V_IDLE);

    // Joystick play 1: 4 coin, 2 gap, 3 start
    joystick_0[5] = 1'b1;
    expect_n(1, "p1_lat", V_IDLE);
    expect_n(4, "p1_coin", V_COIN);
    expect_n(2, "p1_gap", V_GAP);
    expect_n(3, "p1_start", V_START1);
    expect_n(2, "p1_done_held", V_IDLE);
    joystick_0[5] = 1'b0;
    expect_n(1, "p1_release", V_IDLE);

    // Simultaneous edges: player 1 wins; p2 edge in GAP discarded
    joystick_0[5] = 1'b1;
    joystick_1[5] = 1'b1;
    expect_n(1, "both_lat", V_IDLE);
    expect_n(1, "both_coin_a", V_COIN);
    joystick_1[5] = 1'b0;
    expect_n(3, "both_coin_b", V_COIN);
    expect_n(1, "both_gap_a", V_GAP);
    joystick_1[5] = 1'b1;
    expect_n(1, "both_gap_b", V_GAP);
    expect_n(3, "both_start1", V_START1);
    expect_n(2, "both_no_p2", V_IDLE);
    joystick_0[5] = 1'b0;
    joystick_1[5] = 1'b0;
    expect_n(1, "both_release", V_IDLE);

    // Keyboard play 2 adds one cycle for the key register
    ps2(1'b1, 9'h006);
    expect_n(2, "kp2_lat", V_IDLE);
    expect_n(4, "kp2_coin", V_COIN);
    expect_n(2, "kp2_gap", V_GAP);
    expect_n(3, "kp2_start2", V_START2);
    expect_n(1, "kp2_done", V_IDLE);
    ps2(1'b0, 9'h006);
    expect_n(2, "kp2_release", V_IDLE);

    // Extended code is not space
    ps2(1'b1, 9'h129);
    expect_n(3, "ext_ignored", V_IDLE);
    ps2(1'b0, 9'h129);
    expect_n(2, "ext_rel", V_IDLE);

    // Coin1 key held across a running sequence
    ps2(1'b1, 9'h02E);
    expect_n(1, "kc1_lat", V_IDLE);
    expect_n(1, "kc1_held", V_KC1);
    joystick_0[5] = 1'b1;
    expect_n(1, "kc1_seq_lat", V_KC1);
    expect_n(4, "kc1_seq_coin", V_KC1_SC);
    expect_n(2, "kc1_seq_gap", V_KC1_GP);
    expect_n(3, "kc1_seq_start", V_KC1_ST);
    expect_n(1, "kc1_seq_done", V_KC1);
    joystick_0[5] = 1'b0;
    ps2(1'b0, 9'h02E);
    expect_n(1, "kc1_rel_lat", V_KC1);
    expect_n(1, "kc1_rel", V_IDLE);

    // Reset during START, with a toggle mismatch present at release
    joystick_0[5] = 1'b1;
    expect_n(1, "rst_seq_lat", V_IDLE);
    expect_n(4, "rst_seq_coin", V_COIN);
    expect_n(2, "rst_seq_gap", V_GAP);
    expect_n(1, "rst_seq_start", V_START1);
    Reset_I       = 1'b0;
    joystick_0[5] = 1'b0;
    tog           = 1'b1;
    ps2_key       = {1'b1, 1'b1, 9'h029};
    #1;
    check_now("rst_async", V_IDLE);
    expect_n(2, "rst_held", V_IDLE);
    Reset_I = 1'b1;
    expect_n(4, "no_decode_at_release", V_IDLE);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/canyon_input_ctrl.md
Name: canyon_input_ctrl

Overview:
- Front-end input stage for the Canyon Bomber core. It sits directly upstream of canyon_bomber's Coin/Start/Fire inputs.
- Decodes MiSTer ps2_key events into held key states and merges them with joystick_0/joystick_1 bits.
- A one-button credit sequencer turns a single "play" press into a timed coin pulse followed by a start pulse.
- All outputs are registered and active-low, matching canyon_bomber input polarity.

Parameters:
- COIN_CYC, 240000: coin-pulse length in clk_sys cycles (20 ms at 12 MHz).
- GAP_CYC, 120000: idle gap between coin pulse and start pulse, in cycles.
- START_CYC, 240000: start-pulse length in cycles.
- CNT_W, 20: sequencer counter width. Must hold max(COIN_CYC, GAP_CYC, START_CYC).

Ports:
- clk_sys  in  1  system clock (12 MHz).
- Reset_I  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scancode (bit 8 = extended).
- joystick_0  in  16  player 1: [4] fire, [5] play.
- joystick_1  in  16  player 2: [4] fire, [5] play.
- Coin1_O  out  1  active-low coin 1.
- Coin2_O  out  1  active-low coin 2.
- Start1_O  out  1  active-low start 1.
- Start2_O  out  1  active-low start 2.
- Fire1_O  out  1  active-low fire 1.
- Fire2_O  out  1  active-low fire 2.
- seq_busy  out  1  high while the sequencer is not IDLE.

Behaviour:
- Reset (Reset_I=0, async): all *_O = 1; seq_busy = 0; all key regs = 0; toggle reg = 0; primed = 0; state = IDLE; counter = 0.
- Event detect:
  - primed sets on the first clock after reset release. While primed=0, the toggle reg only loads ps2_key[10] and no event is decoded.
  - When primed=1, an event occurs when ps2_key[10] differs from the toggle reg. The toggle reg updates every cycle.
- Key map (full 9-bit compare, extended bit must be 0). Each event sets or clears its key reg to ps2_key[9]:
  - 0x029, 0x014 -> k_fire1
  - 0x01C -> k_fire2
  - 0x005 -> k_play1
  - 0x006 -> k_play2
  - 0x016 -> k_start1
  - 0x01E -> k_start2
  - 0x02E -> k_coin1
  - 0x036 -> k_coin2
  - Unlisted codes are ignored.
  - Space and Ctrl share k_fire1: the last event wins.
- Play requests: p1 = k_play1 | joystick_0[5]; p2 = k_play2 | joystick_1[5]. Each is registered, and a request is its rising edge (0->1) only; holding produces nothing further.
- Sequencer FSM, states IDLE, COIN, GAP, START:
  - IDLE: on a p1 or p2 edge, latch player (p1 priority if both edges fall in the same cycle), counter = 0, go to COIN.
  - COIN: seq_coin=1. When counter = COIN_CYC-1, clear counter and go to GAP; otherwise increment.
  - GAP: nothing asserted. When counter = GAP_CYC-1, go to START.
  - START: seq_start=1 for the latched player. When counter = START_CYC-1, go to IDLE.
  - Edges arriving while not IDLE are discarded (not queued).
  - seq_busy = (state != IDLE), registered.
- Output equations, each registered with one cycle of latency from the inputs/state:
  - Coin1_O = ~(seq_coin | k_coin1)
  - Coin2_O = ~(seq_coin | k_coin2)
  - Start1_O = ~((seq_start & player==1) | k_start1)
  - Start2_O = ~((seq_start & player==2) | k_start2)
  - Fire1_O = ~(k_fire1 | joystick_0[4])
  - Fire2_O = ~(k_fire2 | joystick_1[4])
- Total sequence: coin low for exactly COIN_CYC cycles, then GAP_CYC cycles high, then start low for exactly START_CYC cycles.
- Reset mid-sequence: outputs return to 1 immediately (async) and the FSM returns to IDLE. A play button still held at release does not trigger until it is released and pressed again, because the edge register resets to 0 and primed delays decode. Joystick play held through reset DOES trigger one edge after release: accepted.
- Direct coin/start keys are OR'd with the sequencer and are unaffected by its state.

Test Plan:
- Reset, then ps2_key event {toggle flip, pressed=1, 0x029} -> Fire1_O goes 0 two cycles later. Release event (pressed=0, 0x029) -> Fire1_O = 1. Fire2_O stays 1 throughout.
- With COIN_CYC=4, GAP_CYC=2, START_CYC=3: joystick_0[5] pulse -> Coin1_O/Coin2_O low exactly 4 cycles, 2 cycles gap, Start1_O low exactly 3 cycles. Start2_O stays 1. seq_busy high for 9 cycles.
- Same parameters: p1 and p2 edges in the same cycle -> only the player-1 sequence runs. A second joystick_1[5] edge during GAP -> ignored, and Start2_O never goes low.
- Extended-code event 0x129 -> no output change. Event on 0x02E pressed -> Coin1_O = 0 while held, independent of an active sequencer.
- Assert Reset_I=0 during START -> Start1_O = 1 and seq_busy = 0 asynchronously. A toggle mismatch present at reset release -> no key decoded in the first cycle.
